// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared word width, edge-type enum and edge classifier
// Contents: SPI_WORD_W (default word width), edge_t, edge_classify()
package spi_slave_pkg;

   localparam int SPI_WORD_W = 8;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } edge_t;

   function automatic edge_t edge_classify(input logic i_cur, input logic i_prev);
      edge_t v_edge;
      v_edge = EDGE_NONE;
      case ({i_cur, i_prev})
         2'b10:   v_edge = EDGE_RISE;
         2'b01:   v_edge = EDGE_FALL;
         default: v_edge = EDGE_NONE;
      endcase
      return v_edge;
   endfunction

endpackage

// File: rtl/spi_edge_det.sv
// rtl/spi_edge_det.sv - optional 2-flop synchroniser plus rise/fall detector
// Macro: SPI_SLAVE_SYNC_EN adds the 2-flop synchroniser ahead of the detector.
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-low reset
//   i_sig    asynchronous input signal
//   o_level  sampled level seen by the detector
//   o_rise   level went 0->1 since the previous clk
//   o_fall   level went 1->0 since the previous clk
module spi_edge_det
   import spi_slave_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic  w_level;
   logic  r_prev;
   edge_t w_edge;

`ifdef SPI_SLAVE_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync <= {2{RST_VAL}};
      end else begin
         r_sync <= {r_sync[0], i_sig};
      end
   end

   assign w_level = r_sync[1];
`else
   assign w_level = i_sig;
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_prev <= RST_VAL;
      end else begin
         r_prev <= w_level;
      end
   end

   assign w_edge  = edge_classify(w_level, r_prev);
   assign o_level = w_level;
   assign o_rise  = (w_edge == EDGE_RISE);
   assign o_fall  = (w_edge == EDGE_FALL);

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 word receiver with echo of the previous word on miso
// Macro: SPI_SLAVE_SYNC_EN adds 2-flop synchronisers on sclk, ss and mosi.
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-low reset
//   i_sclk   SPI clock (CPOL=0), async
//   i_ss     slave select, active low, async
//   i_mosi   master-out data, sampled on sclk rise
//   o_miso   slave-out data, updated on sclk fall, 0 while ss high
//   o_data   last completed word
//   o_valid  1-cycle strobe, o_data updated
//   o_sot    1-cycle strobe with the first valid of a transaction
//   o_eot    1-cycle strobe after ss rises
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int WIDTH = SPI_WORD_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sclk,
   input  logic             i_ss,
   input  logic             i_mosi,
   output logic             o_miso,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_sot,
   output logic             o_eot
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic             w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic             w_ss_lvl, w_ss_rise, w_ss_fall;
   logic             w_mosi;
   logic             w_active;
   logic [WIDTH-1:0] w_word;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_tx;
   logic [WIDTH-1:0] r_data;
   logic             r_first;
   logic             r_armed;
   logic             r_valid, r_sot, r_eot, r_miso;

   spi_edge_det #(.RST_VAL(1'b0)) u_sclk_det (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_sig   (i_sclk),
      .o_level (w_sclk_lvl),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_edge_det #(.RST_VAL(1'b1)) u_ss_det (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_sig   (i_ss),
      .o_level (w_ss_lvl),
      .o_rise  (w_ss_rise),
      .o_fall  (w_ss_fall)
   );

`ifdef SPI_SLAVE_SYNC_EN
   // Same depth as the sclk/ss synchronisers so mosi stays aligned with sclk.
   logic [1:0] r_mosi_sync;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_mosi_sync <= 2'b00;
      end else begin
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      end
   end

   assign w_mosi = r_mosi_sync[1];
`else
   assign w_mosi = i_mosi;
`endif

   // ss_rise still counts as selected so a final bit landing with ss release completes.
   assign w_active = r_armed & (~w_ss_lvl | w_ss_rise);
   assign w_word   = {r_shift[WIDTH-2:0], w_mosi};

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_tx    <= '0;
         r_data  <= '0;
         r_first <= 1'b0;
         r_armed <= 1'b0;
         r_valid <= 1'b0;
         r_sot   <= 1'b0;
         r_eot   <= 1'b0;
         r_miso  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_sot   <= 1'b0;
         r_eot   <= w_ss_rise & r_armed;

         // The ss/sclk history registers come out of reset with assumed values, so a
         // transaction is only trusted once the bus has actually been seen idle.
         if (w_ss_lvl && !w_sclk_lvl) begin
            r_armed <= 1'b1;
         end

         if (r_armed && w_ss_fall) begin
            r_cnt   <= '0;
            r_first <= 1'b1;
         end else if (w_sclk_rise && w_active) begin
            r_shift <= w_word;
            if (r_cnt == LAST) begin
               r_data  <= w_word;
               r_tx    <= w_word;
               r_valid <= 1'b1;
               r_sot   <= r_first;
               r_first <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_cnt   <= w_ss_rise ? '0 : r_cnt + 1'b1;
            end
         end else if (w_ss_rise) begin
            r_cnt <= '0;
         end

         if (w_ss_lvl) begin
            r_miso <= 1'b0;
         end else if (w_sclk_fall && r_armed) begin
            r_miso <= r_tx[LAST - r_cnt];
         end
      end
   end

   assign o_miso  = r_miso;
   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_sot   = r_sot;
   assign o_eot   = r_eot;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized scoreboard bench for spi_slave
module tb_spi_slave;

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic       sclk = 1'b0;
   logic       ss   = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [7:0] data;
   logic       valid, sot, eot;

   spi_slave #(.WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_sclk  (sclk),
      .i_ss    (ss),
      .i_mosi  (mosi),
      .o_miso  (miso),
      .o_data  (data),
      .o_valid (valid),
      .o_sot   (sot),
      .o_eot   (eot)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] word;
      logic       first;
      logic       with_eot;
   } exp_t;

   exp_t       q_word[$];
   logic [7:0] tx_words[$];
   int         exp_eot = 0;
   int         n_pass  = 0;
   int         n_total = 0;
   bit         fresh   = 1'b1;
   bit         mon_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every strobe the DUT raises must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst && mon_en) begin
         if (valid) begin
            if (q_word.size() == 0) begin
               chk("valid_without_expected_word", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q_word.pop_front();
               chk("data", {24'd0, data}, {24'd0, e.word});
               chk("sot", {31'd0, sot}, {31'd0, e.first});
               chk("eot_with_valid", {31'd0, eot}, {31'd0, e.with_eot});
            end
         end else begin
            if (sot) chk("sot_without_valid", 32'd1, 32'd0);
            if (eot) begin
               chk("eot_expected", (exp_eot > 0) ? 32'd1 : 32'd0, 32'd1);
               if (exp_eot > 0) exp_eot--;
            end
         end
      end
   end

   // One bit = 1 clk low (mosi set) + 1 clk high; miso sampled as the master raises sclk.
   task automatic send(input logic [7:0] w, input int nbits, input bit end_with_ss,
                       output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         sclk = 1'b0;
         mosi = w[7-i];
         @(negedge clk);
         rx[7-i] = miso;
         sclk = 1'b1;
         if (end_with_ss && i == nbits - 1) ss = 1'b1;
      end
   endtask

   // Reference: each full word in a selected burst yields one valid with data=word,
   // sot only on the first; the master reads back the previous word of the burst.
   task automatic txn(input int abort_bits, input bit sim_end);
      logic [7:0] prev, rx, w;
      bit         last;
      int         nw;
      nw   = tx_words.size();
      prev = 8'h00;
      @(negedge clk);
      ss = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < nw; k++) begin
         w    = tx_words[k];
         last = sim_end && (k == nw - 1) && (abort_bits == 0);
         q_word.push_back('{w, (k == 0), last});
         send(w, 8, last, rx);
         if (k > 0) chk("miso_echo", {24'd0, rx}, {24'd0, prev});
         else if (fresh) chk("miso_first_after_reset", {24'd0, rx}, 32'd0);
         prev  = w;
         fresh = 1'b0;
      end
      if (abort_bits > 0) send(8'($urandom), abort_bits, 1'b0, rx);
      @(negedge clk);
      sclk = 1'b0;
      if (!(sim_end && abort_bits == 0 && nw > 0)) begin
         @(negedge clk);
         ss = 1'b1;
         exp_eot++;
      end
      repeat (3) @(negedge clk);
      tx_words.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: bench did not complete");
      n_total++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      logic [7:0] rx;
      repeat (3) @(negedge clk);
      chk("reset_data", {24'd0, data}, 32'd0);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_sot", {31'd0, sot}, 32'd0);
      chk("reset_eot", {31'd0, eot}, 32'd0);
      chk("reset_miso", {31'd0, miso}, 32'd0);
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      tx_words = '{8'hFF};
      txn(0, 1'b0);
      tx_words = '{8'h00, 8'h01, 8'h02, 8'h03};
      txn(0, 1'b0);
      txn(5, 1'b0);
      tx_words = '{8'hA5};
      txn(0, 1'b0);
      tx_words = '{8'h3C, 8'hC3};
      txn(0, 1'b0);
      chk("miso_idle", {31'd0, miso}, 32'd0);
      tx_words = '{8'h5A};
      txn(0, 1'b1);

      // Reset in the middle of a word, then a full word without a fresh ss fall.
      @(negedge clk);
      ss = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h96, 3, 1'b0, rx);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_data", {24'd0, data}, 32'd0);
      chk("midreset_valid", {31'd0, valid}, 32'd0);
      chk("midreset_sot", {31'd0, sot}, 32'd0);
      chk("midreset_eot", {31'd0, eot}, 32'd0);
      chk("midreset_miso", {31'd0, miso}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      send(8'h77, 8, 1'b0, rx);
      @(negedge clk);
      sclk = 1'b0;
      repeat (3) @(negedge clk);
      ss = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_word_without_ss_fall", {24'd0, data}, 32'd0);
      fresh    = 1'b1;
      tx_words = '{8'hE1, 8'h1E};
      txn(0, 1'b0);

      repeat (25) begin
         int nw, ab;
         bit se;
         nw = $urandom_range(0, 4);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         if (nw == 0 && ab == 0) nw = 1;
         se = (ab == 0) && ($urandom_range(0, 2) == 0);
         for (int k = 0; k < nw; k++) tx_words.push_back(8'($urandom));
         txn(ab, se);
      end

      repeat (5) @(negedge clk);
      chk("pending_words", q_word.size(), 32'd0);
      chk("pending_eot", exp_eot, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
